// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator controller: op codes, FSM states,
// operand width and BCD entry layout.
package calc_pkg;

    localparam int VAL_W      = 14;
    localparam int NUM_DIGITS = 4;
    localparam int NUM_BTNS   = 9;
    localparam int OP_BASE    = 4;
    localparam int EQ_IDX     = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_SHOW_RES = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // Index 0 is the thousands digit, index NUM_DIGITS-1 the units digit.
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [VAL_W-1:0] bcd_to_bin(input bcd_t d);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            acc = acc * 10 + 32'(d[i]);
        end
        return VAL_W'(acc);
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// ALU request/response handshake between calc_ctrl (master) and the ALU (slave).
interface calc_ctrl_if;
    import calc_pkg::*;

    logic             alu_start;
    logic [1:0]       alu_op;
    logic [VAL_W-1:0] alu_a;
    logic [VAL_W-1:0] alu_b;
    logic             alu_done;
    logic             alu_err;
    logic [VAL_W-1:0] alu_result;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_err, alu_result
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_err, alu_result
    );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
// Optional auto-repeat of held buttons under CALC_CTRL_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef CALC_CTRL_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;

`ifdef CALC_CTRL_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            pulse_reg  <= 1'b0;
`ifdef CALC_CTRL_AUTOREPEAT_EN
            rpt_reg    <= '0;
`endif
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            pulse_reg <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
                pulse_reg  <= sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
`ifdef CALC_CTRL_AUTOREPEAT_EN
            if (REPEAT_EN && stable_reg && sync_reg[1]) begin
                if (rpt_reg == RPT_MAX) begin
                    rpt_reg   <= '0;
                    pulse_reg <= 1'b1;
                end else begin
                    rpt_reg <= rpt_reg + RPT_W'(1);
                end
            end else begin
                rpt_reg <= '0;
            end
`endif
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/calc_ctrl.sv
// Four-digit BCD calculator front end: debounced keys, operand entry, ALU handshake
// and registered display. Build macro: CALC_CTRL_AUTOREPEAT_EN (held-digit auto-repeat).
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ALU_TIMEOUT     = 256,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn,
    calc_ctrl_if.master         alu,
    output logic [VAL_W-1:0]    disp_val,
    output logic                disp_err,
    output logic [1:0]          disp_op
);

    localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ALU_TIMEOUT - 1);

    logic [NUM_BTNS-1:0]   ev;
    logic [NUM_DIGITS-1:0] dig_ev;
    logic [3:0]            op_ev;
    logic                  eq_ev;
    logic                  any_op;
    op_t                   op_sel;

    state_t           state_reg, state_next;
    bcd_t             entry_reg, entry_next, entry_inc, entry_fresh;
    logic [VAL_W-1:0] entry_bin;
    logic [VAL_W-1:0] a_reg, a_next;
    op_t              op_reg, op_next;
    logic [VAL_W-1:0] result_reg, result_next;
    logic             alu_start_reg, alu_start_next;
    logic [VAL_W-1:0] alu_a_reg, alu_a_next;
    logic [VAL_W-1:0] alu_b_reg, alu_b_next;
    op_t              alu_op_reg, alu_op_next;
    logic [VAL_W-1:0] disp_val_reg, disp_val_next;
    logic             disp_err_reg, disp_err_next;
    op_t              disp_op_reg;
    logic [TMO_W-1:0] tmo_reg;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef CALC_CTRL_AUTOREPEAT_EN
                ,
                .REPEAT_CYCLES  (REPEAT_CYCLES),
                .REPEAT_EN      (gi < NUM_DIGITS)
`endif
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn[gi]),
                .pulse(ev[gi])
            );
        end
    endgenerate

    assign dig_ev = ev[NUM_DIGITS-1:0];
    assign op_ev  = ev[OP_BASE+3:OP_BASE];
    assign eq_ev  = ev[EQ_IDX];
    assign any_op = |op_ev;

    // Lowest-indexed operator key wins when several land together.
    always_comb begin
        op_sel = OP_ADD;
        for (int i = 3; i >= 0; i--) begin
            if (op_ev[i]) op_sel = op_t'(i[1:0]);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign entry_inc[gi]   = dig_ev[gi] ? bcd_inc(entry_reg[gi]) : entry_reg[gi];
            assign entry_fresh[gi] = dig_ev[gi] ? 4'd1 : 4'd0;
        end
    endgenerate

    assign entry_bin = bcd_to_bin(entry_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ENTER_A;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_ENTER_A: begin
                if (any_op) state_next = ST_ENTER_B;
            end
            ST_ENTER_B: begin
                if (!any_op && eq_ev) state_next = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                if (alu.alu_done) begin
                    state_next = alu.alu_err ? ST_ERROR : ST_SHOW_RES;
                end else if (tmo_reg == TMO_MAX) begin
                    state_next = ST_ERROR;
                end
            end
            ST_SHOW_RES: begin
                if (any_op) begin
                    state_next = ST_ENTER_B;
                end else if (!eq_ev && (|dig_ev)) begin
                    state_next = ST_ENTER_A;
                end
            end
            ST_ERROR: begin
                if (|ev) state_next = ST_ENTER_A;
            end
            default: state_next = ST_ENTER_A;
        endcase
    end

    // Operator/EQUALS decoding comes first in each state so that digit events
    // arriving in the same cycle fall through unused.
    always_comb begin
        entry_next     = entry_reg;
        a_next         = a_reg;
        op_next        = op_reg;
        result_next    = result_reg;
        alu_start_next = 1'b0;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_op_next    = alu_op_reg;
        unique case (state_reg)
            ST_ENTER_A: begin
                if (any_op) begin
                    a_next     = entry_bin;
                    op_next    = op_sel;
                    entry_next = '0;
                end else if (!eq_ev) begin
                    entry_next = entry_inc;
                end
            end
            ST_ENTER_B: begin
                if (any_op) begin
                    op_next = op_sel;
                end else if (eq_ev) begin
                    alu_start_next = 1'b1;
                    alu_a_next     = a_reg;
                    alu_b_next     = entry_bin;
                    alu_op_next    = op_reg;
                end else begin
                    entry_next = entry_inc;
                end
            end
            ST_WAIT_ALU: begin
                if (alu.alu_done && !alu.alu_err) result_next = alu.alu_result;
            end
            ST_SHOW_RES: begin
                if (any_op) begin
                    a_next     = result_reg;
                    op_next    = op_sel;
                    entry_next = '0;
                end else if (!eq_ev && (|dig_ev)) begin
                    entry_next = entry_fresh;
                end
            end
            ST_ERROR: begin
                if (|ev) begin
                    entry_next = '0;
                    a_next     = '0;
                    op_next    = OP_ADD;
                end
            end
            default: ;
        endcase
    end

    // Display is computed from next-state values so it tracks the FSM without lag.
    always_comb begin
        disp_val_next = bcd_to_bin(entry_next);
        if (state_next == ST_SHOW_RES) begin
            disp_val_next = result_next;
        end else if (state_next == ST_ERROR) begin
            disp_val_next = '0;
        end
        disp_err_next = (state_next == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg     <= '0;
            a_reg         <= '0;
            op_reg        <= OP_ADD;
            result_reg    <= '0;
            alu_start_reg <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= OP_ADD;
            disp_val_reg  <= '0;
            disp_err_reg  <= 1'b0;
            disp_op_reg   <= OP_ADD;
            tmo_reg       <= '0;
        end else begin
            entry_reg     <= entry_next;
            a_reg         <= a_next;
            op_reg        <= op_next;
            result_reg    <= result_next;
            alu_start_reg <= alu_start_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_op_reg    <= alu_op_next;
            disp_val_reg  <= disp_val_next;
            disp_err_reg  <= disp_err_next;
            disp_op_reg   <= op_next;
            tmo_reg       <= (state_reg == ST_WAIT_ALU) ? tmo_reg + TMO_W'(1) : '0;
        end
    end

    assign alu.alu_start = alu_start_reg;
    assign alu.alu_a     = alu_a_reg;
    assign alu.alu_b     = alu_b_reg;
    assign alu.alu_op    = alu_op_reg;
    assign disp_val      = disp_val_reg;
    assign disp_err      = disp_err_reg;
    assign disp_op       = disp_op_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed vector table, multi-cycle corner
// sequences and randomized key presses against a transaction-level calculator model.
module tb_calc_ctrl;

    localparam int DB  = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  btn;
    logic [13:0] disp_val;
    logic        disp_err;
    logic [1:0]  disp_op;

    calc_ctrl_if aif();

    calc_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .ALU_TIMEOUT    (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .alu     (aif),
        .disp_val(disp_val),
        .disp_err(disp_err),
        .disp_op (disp_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ALU reference: unsigned 0..9999 results, error on overflow/negative/div0.
    function automatic void alu_ref(input int a, input int b, input int op,
                                    output int r, output bit e);
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        e = (r < 0) || (r > 9999) || (op == 3 && b == 0);
    endfunction

    // ALU responder
    int start_cnt = 0, start_cyc = 0, last_a = 0, last_b = 0, last_op = 0;
    bit alu_silent = 1'b0;
    int late_req = 0, late_seen = 0;

    initial begin
        int r;
        bit e;
        aif.alu_done   = 1'b0;
        aif.alu_err    = 1'b0;
        aif.alu_result = '0;
        forever begin
            @(negedge clk);
            if (late_req != late_seen) begin
                late_seen      = late_req;
                aif.alu_done   = 1'b1;
                aif.alu_err    = 1'b0;
                aif.alu_result = 14'd1234;
                @(negedge clk);
                aif.alu_done = 1'b0;
            end else if (aif.alu_start) begin
                start_cnt++;
                start_cyc = cyc;
                last_a    = int'(aif.alu_a);
                last_b    = int'(aif.alu_b);
                last_op   = int'(aif.alu_op);
                if (!alu_silent) begin
                    alu_ref(last_a, last_b, last_op, r, e);
                    repeat (4) @(negedge clk);
                    aif.alu_done   = 1'b1;
                    aif.alu_err    = e;
                    aif.alu_result = e ? 14'd0 : 14'(r);
                    @(negedge clk);
                    aif.alu_done = 1'b0;
                end
            end
        end
    end

    // Transaction-level calculator model
    typedef enum {M_ENTER_A, M_ENTER_B, M_SHOW_RES, M_ERROR} mstate_t;
    mstate_t mst;
    int ment, ma, mop, mres, mstarts, mexp_a, mexp_b, mexp_op;

    function automatic void model_reset();
        mst = M_ENTER_A; ment = 0; ma = 0; mop = 0; mres = 0; mstarts = 0;
    endfunction

    function automatic void add_digits(input logic [3:0] dig);
        int place, d;
        for (int i = 0; i < 4; i++) begin
            if (dig[i]) begin
                place = (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1;
                d     = (ment / place) % 10;
                ment  = ment + (((d + 1) % 10) - d) * place;
            end
        end
    endfunction

    function automatic void model_event(input logic [8:0] m);
        int opi, r;
        bit e;
        opi = 0;
        for (int i = 3; i >= 0; i--) if (m[4+i]) opi = i;
        case (mst)
            M_ENTER_A: begin
                if (m[7:4] != 0) begin ma = ment; mop = opi; ment = 0; mst = M_ENTER_B; end
                else if (!m[8]) add_digits(m[3:0]);
            end
            M_ENTER_B: begin
                if (m[7:4] != 0) mop = opi;
                else if (m[8]) begin
                    mstarts++; mexp_a = ma; mexp_b = ment; mexp_op = mop;
                    alu_ref(ma, ment, mop, r, e);
                    if (e) mst = M_ERROR;
                    else begin mres = r; mst = M_SHOW_RES; end
                end else add_digits(m[3:0]);
            end
            M_SHOW_RES: begin
                if (m[7:4] != 0) begin ma = mres; mop = opi; ment = 0; mst = M_ENTER_B; end
                else if (!m[8] && m[3:0] != 0) begin ment = 0; add_digits(m[3:0]); mst = M_ENTER_A; end
            end
            default: begin
                if (m != 0) begin ment = 0; ma = 0; mop = 0; mst = M_ENTER_A; end
            end
        endcase
    endfunction

    function automatic int model_disp();
        return (mst == M_SHOW_RES) ? mres : (mst == M_ERROR) ? 0 : ment;
    endfunction

    function automatic logic [8:0] rand_mask();
        logic [3:0] d;
        logic [3:0] o;
        d = 4'($urandom_range(1, 15));
        o = 4'($urandom_range(1, 15));
        case ($urandom_range(0, 5))
            0: return 9'(1 << $urandom_range(0, 3));
            1: return {5'b0, d};
            2: return 9'(1 << (4 + $urandom_range(0, 3)));
            3: return {1'b0, o, d};
            4: return 9'h100;
            default: return {5'b10000, d};
        endcase
    endfunction

    task automatic press(input logic [8:0] m);
        @(negedge clk);
        btn = m;
        repeat (10) @(negedge clk);
        btn = '0;
        repeat (12) @(negedge clk);
        $display("press btn=%03h -> disp_val=%0d disp_err=%0d disp_op=%0d",
                 m, disp_val, disp_err, disp_op);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit         rst_first;
        logic [8:0] mask;
        int         exp_val;
        bit         exp_err;
        int         exp_op;
        bit         chk_alu;
        int         exp_a;
        int         exp_b;
        int         exp_aop;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [8:0] m, input int v, input bit e,
                                input int o, input bit c, input int a, input int b, input int ao);
        vec_t x;
        x.rst_first = r; x.mask = m; x.exp_val = v; x.exp_err = e; x.exp_op = o;
        x.chk_alu = c; x.exp_a = a; x.exp_b = b; x.exp_aop = ao;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   base, prev, ecyc, s0;
        bit   got;
        logic [8:0] m;

        rst = 1'b1;
        btn = '0;

        for (int k = 1; k <= 8; k++) vecs.push_back(mk(k == 1, 9'h00F, 1111 * k, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9'h004, 10, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h008, 11, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h008, 12, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h010, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++) vecs.push_back(mk(0, 9'h004, 10 * k, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h100, 42, 0, 0, 1, 12, 30, 0));
        for (int k = 1; k <= 11; k++) vecs.push_back(mk(0, 9'h008, k % 10, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h0CF, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h0A0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h002, 100, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9'h100, 0, 1, 1, 1, 1, 100, 1));
        vecs.push_back(mk(0, 9'h001, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        do_reset();
        check("rst_disp_val", disp_val, 0);
        check("rst_disp_err", disp_err, 0);
        check("rst_disp_op", disp_op, 0);
        check("rst_alu_start", aif.alu_start, 0);
        check("rst_alu_a", aif.alu_a, 0);
        check("rst_alu_b", aif.alu_b, 0);

        // Directed vector table
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst_first) do_reset();
            s0 = start_cnt;
            press(vecs[k].mask);
            check($sformatf("tbl%0d_val", k), disp_val, vecs[k].exp_val);
            check($sformatf("tbl%0d_err", k), disp_err, int'(vecs[k].exp_err));
            check($sformatf("tbl%0d_op", k), disp_op, vecs[k].exp_op);
            if (vecs[k].chk_alu) begin
                check($sformatf("tbl%0d_starts", k), start_cnt - s0, 1);
                check($sformatf("tbl%0d_alu_a", k), last_a, vecs[k].exp_a);
                check($sformatf("tbl%0d_alu_b", k), last_b, vecs[k].exp_b);
                check($sformatf("tbl%0d_alu_op", k), last_op, vecs[k].exp_aop);
            end
        end

        // ALU timeout
        do_reset();
        press(9'h010);
        alu_silent = 1'b1;
        s0 = start_cnt;
        press(9'h100);
        check("tmo_start", start_cnt - s0, 1);
        check("tmo_early_err", disp_err, 0);
        got = 1'b0;
        ecyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (disp_err) begin got = 1'b1; ecyc = cyc; end
        end
        check("tmo_seen", int'(got), 1);
        check("tmo_cycles", ecyc - start_cyc, TMO);
        check("tmo_disp_val", disp_val, 0);
        alu_silent = 1'b0;
        press(9'h001);
        check("tmo_clear_val", disp_val, 0);
        check("tmo_clear_err", disp_err, 0);

        // Bouncing b2, then steady press
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn = 9'h002;
            repeat (2) @(negedge clk);
            btn = 9'h000;
            repeat (2) @(negedge clk);
        end
        check("bounce_quiet", disp_val, 0);
        press(9'h002);
        check("bounce_val", disp_val, 100);

        // Reset during WAIT_ALU, then a late alu_done
        do_reset();
        press(9'h001);
        press(9'h010);
        press(9'h001);
        alu_silent = 1'b1;
        press(9'h100);
        check("abort_alu_a", aif.alu_a, 1000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_req++;
        repeat (4) @(negedge clk);
        alu_silent = 1'b0;
        check("abort_disp_val", disp_val, 0);
        check("abort_disp_err", disp_err, 0);
        check("abort_disp_op", disp_op, 0);
        check("abort_alu_start", aif.alu_start, 0);
        check("abort_alu_a0", aif.alu_a, 0);
        check("abort_alu_b0", aif.alu_b, 0);
        press(9'h008);
        press(9'h040);
        check("abort_enter_a_val", disp_val, 0);
        check("abort_enter_a_op", disp_op, 2);

        // Randomized presses against the model
        do_reset();
        model_reset();
        base = start_cnt;
        for (int t = 0; t < 40; t++) begin
            m = rand_mask();
            prev = mstarts;
            model_event(m);
            press(m);
            check($sformatf("rnd%0d_val", t), disp_val, model_disp());
            check($sformatf("rnd%0d_err", t), disp_err, int'(mst == M_ERROR));
            check($sformatf("rnd%0d_op", t), disp_op, mop);
            check($sformatf("rnd%0d_starts", t), start_cnt - base, mstarts);
            if (mstarts != prev) begin
                check($sformatf("rnd%0d_alu_a", t), last_a, mexp_a);
                check($sformatf("rnd%0d_alu_b", t), last_b, mexp_b);
                check($sformatf("rnd%0d_alu_op", t), last_op, mexp_op);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
